// File: rtl/alu_control.sv
// alu_control: registered ALU-control decoder for the MIPS datapath.
// Merges the main-control ALUOp class with the R-type funct field into a
// 4-bit ALU operation select, and flags R-type funct codes the ALU cannot run.
module alu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] ALUCon,
  output logic       illegal
);

  // ALU operation selects understood by the downstream ALU
  typedef enum logic [3:0] {
    CON_AND  = 4'b0000,
    CON_OR   = 4'b0001,
    CON_ADD  = 4'b0010,
    CON_XOR  = 4'b0011,
    CON_SUB  = 4'b0110,
    CON_SLT  = 4'b0111,
    CON_SLTU = 4'b1000,
    CON_NOR  = 4'b1100,
    CON_NOP  = 4'b1111
  } aluConE;

  // Operation classes produced by the main decoder
  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ORI    = 2'b11
  } aluOpE;

  // R-type funct codes the ALU supports
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  aluConE aluCon_d, aluCon_q;
  logic   illegal_d, illegal_q;

  // Combinational decode: the class picks a fixed op, except R-type which needs an exact funct match
  always_comb begin
    aluCon_d  = CON_ADD;
    illegal_d = 1'b0;
    case (ALUOp)
      OP_MEM:    aluCon_d = CON_ADD;
      OP_BRANCH: aluCon_d = CON_SUB;
      OP_ORI:    aluCon_d = CON_OR;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: aluCon_d = CON_ADD;
          FN_SUB, FN_SUBU: aluCon_d = CON_SUB;
          FN_AND:          aluCon_d = CON_AND;
          FN_OR:           aluCon_d = CON_OR;
          FN_XOR:          aluCon_d = CON_XOR;
          FN_NOR:          aluCon_d = CON_NOR;
          FN_SLT:          aluCon_d = CON_SLT;
          FN_SLTU:         aluCon_d = CON_SLTU;
          default: begin
            aluCon_d  = CON_NOP;
            illegal_d = 1'b1;
          end
        endcase
      end
      default: begin
        aluCon_d  = CON_ADD;
        illegal_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset wins over the decode captured on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      aluCon_q  <= CON_ADD;
      illegal_q <= 1'b0;
    end else begin
      aluCon_q  <= aluCon_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUCon  = aluCon_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: self-checking bench for alu_control, using a table-driven
// reference model of the decode rules plus directed and randomized stimulus.
module tb_alu_control;

  logic       clk;
  logic       rst;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [3:0] ALUCon;
  logic       illegal;

  int checkCount = 0;
  int passCount  = 0;

  // Supported R-type funct codes and the op each one selects
  logic [3:0] rtypeTable [logic [5:0]];
  logic [5:0] legalFuncts [$];

  alu_control dut (
    .clk    (clk),
    .rst    (rst),
    .ALUOp  (ALUOp),
    .funct  (funct),
    .ALUCon (ALUCon),
    .illegal(illegal)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
  endtask

  // Reference behaviour: reset value, fixed op per class, table lookup for R-type
  task automatic refModel(input logic [1:0] op, input logic [5:0] fn, input logic r,
                          output logic [3:0] expCon, output logic expIll);
    expIll = 1'b0;
    if (r)              expCon = 4'd2;
    else if (op == 2'd0) expCon = 4'd2;
    else if (op == 2'd1) expCon = 4'd6;
    else if (op == 2'd3) expCon = 4'd1;
    else if (rtypeTable.exists(fn)) expCon = rtypeTable[fn];
    else begin
      expCon = 4'hF;
      expIll = 1'b1;
    end
  endtask

  // Drives one cycle of inputs, then checks the registered result after the edge
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [5:0] fn, input logic r);
    logic [3:0] expCon;
    logic       expIll;
    @(negedge clk);
    ALUOp = op;
    funct = fn;
    rst   = r;
    refModel(op, fn, r, expCon, expIll);
    @(posedge clk);
    #1;
    checkOutput({tag, ".ALUCon"}, ALUCon, expCon);
    checkOutput({tag, ".illegal"}, {3'b000, illegal}, {3'b000, expIll});
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] fn;
    logic       r;

    rtypeTable[6'd32] = 4'd2;   // add
    rtypeTable[6'd33] = 4'd2;   // addu
    rtypeTable[6'd34] = 4'd6;   // sub
    rtypeTable[6'd35] = 4'd6;   // subu
    rtypeTable[6'd36] = 4'd0;   // and
    rtypeTable[6'd37] = 4'd1;   // or
    rtypeTable[6'd38] = 4'd3;   // xor
    rtypeTable[6'd39] = 4'd12;  // nor
    rtypeTable[6'd42] = 4'd7;   // slt
    rtypeTable[6'd43] = 4'd8;   // sltu
    foreach (rtypeTable[k]) legalFuncts.push_back(k);

    rst   = 1'b1;
    ALUOp = 2'b10;
    funct = 6'b100100;

    // Reset held two cycles with an AND decode pending, then released
    applyStimulus("reset0", 2'b10, 6'b100100, 1'b1);
    applyStimulus("reset1", 2'b10, 6'b100100, 1'b1);
    applyStimulus("release", 2'b10, 6'b100100, 1'b0);
    checkOutput("releaseIsAnd", ALUCon, 4'b0000);

    // Non-R-type classes ignore funct
    applyStimulus("memAdd", 2'b00, 6'b100000, 1'b0);
    applyStimulus("memOddFn", 2'b00, 6'b110000, 1'b0);
    applyStimulus("branch", 2'b01, 6'b101010, 1'b0);
    applyStimulus("ori", 2'b11, 6'b100000, 1'b0);

    // R-type sweep, one code per cycle
    applyStimulus("rAdd", 2'b10, 6'b100000, 1'b0);
    applyStimulus("rSub", 2'b10, 6'b100010, 1'b0);
    applyStimulus("rAnd", 2'b10, 6'b100100, 1'b0);
    applyStimulus("rOr", 2'b10, 6'b100101, 1'b0);
    applyStimulus("rSlt", 2'b10, 6'b101010, 1'b0);
    applyStimulus("rNor", 2'b10, 6'b100111, 1'b0);
    applyStimulus("rSltu", 2'b10, 6'b101011, 1'b0);
    applyStimulus("rXor", 2'b10, 6'b100110, 1'b0);
    applyStimulus("rAddu", 2'b10, 6'b100001, 1'b0);
    applyStimulus("rSubu", 2'b10, 6'b100011, 1'b0);

    // Unsupported funct codes, then recovery on a non-R-type op
    applyStimulus("illZero", 2'b10, 6'b000000, 1'b0);
    applyStimulus("illHigh", 2'b10, 6'b110000, 1'b0);
    checkOutput("illHighFlag", {3'b000, illegal}, 4'b0001);
    applyStimulus("illClear", 2'b00, 6'b110000, 1'b0);

    // Reset asserted mid-stream over an illegal decode, then normal again
    applyStimulus("midReset", 2'b10, 6'b111111, 1'b1);
    applyStimulus("afterMid", 2'b10, 6'b100110, 1'b0);

    // Randomized back-to-back traffic with sporadic reset
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        fn = legalFuncts[$urandom_range(0, legalFuncts.size() - 1)];
      else
        fn = 6'($urandom);
      r = ($urandom_range(0, 15) == 0);
      applyStimulus("rand", op, fn, r);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_control.md
# alu_control

Registered ALU-control decoder for the single-cycle/pipelined MIPS datapath. It sits between the main control unit and the ALU. It combines the 2-bit ALUOp class from the main decoder with the 6-bit R-type funct field to produce the 4-bit ALU operation select. The result is registered on the system clock and flags unsupported R-type funct codes.

## Interface
- No parameters; all widths fixed.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ALUOp  input  2  operation class from main control:
  - 00 = load/store/addi (add)
  - 01 = branch (sub)
  - 10 = R-type (decode funct)
  - 11 = ori (or)
- funct  input  6  instruction bits [5:0]; examined only when ALUOp = 10.
- ALUCon  output  4  registered ALU operation select.
- illegal  output  1  registered; high when ALUOp = 10 and funct is unsupported.

## Operation
- ALUCon encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0110 SUB
  - 0111 SLT
  - 1000 SLTU
  - 1100 NOR
  - 1111 NOP/illegal
- ALUOp = 00 -> 0010 (ADD) for any funct; illegal = 0.
- ALUOp = 01 -> 0110 (SUB) for any funct; illegal = 0.
- ALUOp = 11 -> 0001 (OR) for any funct; illegal = 0.
- ALUOp = 10 -> full 6-bit exact match on funct:
  - 100000 add -> 0010
  - 100001 addu -> 0010
  - 100010 sub -> 0110
  - 100011 subu -> 0110
  - 100100 and -> 0000
  - 100101 or -> 0001
  - 100110 xor -> 0011
  - 100111 nor -> 1100
  - 101010 slt -> 0111
  - 101011 sltu -> 1000
  - any other funct -> ALUCon = 1111, illegal = 1.
- X/Z on inputs is not required to be handled; all 256 defined input combinations must decode deterministically.

## Timing
- Decode is combinational; the outputs are registered. ALUCon and illegal reflect the ALUOp/funct sampled at rising edge N, valid after edge N (1-cycle latency).
- No enable: a new decode is captured every cycle; inputs may change every cycle.
- Reset: with rst = 1 at a rising edge, ALUCon <= 0010 (ADD) and illegal <= 0, regardless of inputs.
- Reset dominates decode on the same edge. The first decode after rst deasserts appears one edge later.
- Reset asserted mid-stream overrides the pending decode for that edge only.
- No internal state other than the output registers.

## Test plan
- Reset: rst = 1 for 2 cycles with ALUOp = 10, funct = 100100 -> ALUCon = 0010, illegal = 0. First edge after release -> ALUCon = 0000.
- Non-R-type classes ignore funct:
  - ALUOp = 00, funct = 100000 -> 0010
  - ALUOp = 00, funct = 110000 -> 0010
  - ALUOp = 01, funct = 101010 -> 0110
  - ALUOp = 11, funct = 100000 -> 0001
  - illegal = 0 throughout.
- R-type sweep, ALUOp = 10:
  - 100000 -> 0010
  - 100010 -> 0110
  - 100100 -> 0000
  - 100101 -> 0001
  - 101010 -> 0111
  - 100111 -> 1100
  - 101011 -> 1000
  - 100110 -> 0011
  - each appears exactly one edge after being applied.
- Illegal funct: ALUOp = 10 with funct = 000000 or 110000 -> ALUCon = 1111, illegal = 1. Next cycle ALUOp = 00 -> illegal returns to 0.
- Back-to-back changes every cycle (random ALUOp/funct for 1000 cycles) -> outputs match a reference model delayed by one cycle; assert rst randomly and check the reset value on those edges.
